// File: rtl/gpio_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gpio_pkg : shared constants and helpers for the gpio_ctrl block      |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package gpio_pkg;

    localparam logic IT_LEVEL = 1'b0;
    localparam logic IT_EDGE  = 1'b1;
    localparam logic POL_LOW  = 1'b0;
    localparam logic POL_HIGH = 1'b1;

    // Width of a counter that must hold 0..cycles inclusive.
    function automatic int unsigned dbc_cnt_width(input int unsigned cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

    function automatic logic pin_event(input logic it, input logic ip,
                                       input logic val, input logic prev);
        logic ev;
        ev = 1'b0;
        case ({it, ip})
            {IT_LEVEL, POL_HIGH}: ev = val;
            {IT_LEVEL, POL_LOW }: ev = ~val;
            {IT_EDGE,  POL_HIGH}: ev = val & ~prev;
            {IT_EDGE,  POL_LOW }: ev = ~val & prev;
            default:              ev = 1'b0;
        endcase
        return ev;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gpio_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gpio_debounce : per-pin stable-level filter, WIDTH pins wide         |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module gpio_debounce
    import gpio_pkg::*;
#(
    parameter int WIDTH           = 16,
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] sync_i,
    output logic [WIDTH-1:0] val_o
);

    localparam int CNT_W = int'(dbc_cnt_width(DEBOUNCE_CYCLES));
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             stable_q;
        logic             stable_d;

        // The accepting cycle is the DEBOUNCE_CYCLES-th consecutive mismatch.
        always_comb begin
            cnt_d    = '0;
            stable_d = stable_q;
            if (sync_i[i] != stable_q) begin
                if (cnt_q == CNT_LAST) begin
                    stable_d = sync_i[i];
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                cnt_q    <= '0;
                stable_q <= 1'b0;
            end else begin
                cnt_q    <= cnt_d;
                stable_q <= stable_d;
            end
        end

        assign val_o[i] = stable_q;
    end

endmodule
`default_nettype wire

// File: rtl/gpio_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gpio_ctrl : GPIO with input sync, edge/level IRQ and sticky status.  |
// | Optional debouncer when GPIO_DEBOUNCE_EN is defined.                  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module gpio_ctrl
    import gpio_pkg::*;
#(
    parameter int WIDTH           = 16,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    output logic [WIDTH-1:0] WGPIODIN,
    input  logic [WIDTH-1:0] WGPIODOUT,
    input  logic [WIDTH-1:0] WGPIOPU,
    input  logic [WIDTH-1:0] WGPIOPD,
    input  logic [WIDTH-1:0] WGPIODIR,
    input  logic [WIDTH-1:0] WGPIOIM,
    input  logic [WIDTH-1:0] WGPIOIT,
    input  logic [WIDTH-1:0] WGPIOIP,
    input  logic [WIDTH-1:0] WGPIOIC,
    output logic [WIDTH-1:0] WGPIOIS,
    output logic             IRQ,
    input  logic [WIDTH-1:0] GPIOIN,
    output logic [WIDTH-1:0] GPIOOUT,
    output logic [WIDTH-1:0] GPIOPU,
    output logic [WIDTH-1:0] GPIOPD,
    output logic [WIDTH-1:0] GPIOOEN
);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] val;
    logic [WIDTH-1:0] evt;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] status_q;
    logic [WIDTH-1:0] status_d;

    assign GPIOOUT = WGPIODOUT;
    assign GPIOOEN = WGPIODIR;
    assign GPIOPU  = WGPIOPU;
    assign GPIOPD  = WGPIOPD;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= GPIOIN;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
    gpio_debounce #(
        .WIDTH           (WIDTH),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk_i  (HCLK),
        .rst_ni (HRESETn),
        .sync_i (sync),
        .val_o  (val)
    );
`else
    assign val = sync;
`endif

    assign WGPIODIN = val;

    always_comb begin
        evt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            evt[i] = pin_event(WGPIOIT[i], WGPIOIP[i], val[i], prev_q[i]);
        end
    end

    // A new event outranks a same-cycle clear.
    assign status_d = evt | (status_q & ~WGPIOIC);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            prev_q   <= '0;
            status_q <= '0;
        end else begin
            prev_q   <= val;
            status_q <= status_d;
        end
    end

    assign WGPIOIS = status_q;
    assign IRQ     = |(status_q & WGPIOIM);

endmodule
`default_nettype wire

// File: tb/tb_gpio_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_gpio_ctrl : self-checking bench for gpio_ctrl (WIDTH=16, SS=2)    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_gpio_ctrl;

    localparam int W  = 16;
    localparam int SS = 2;
    localparam int DB = 8;
`ifdef GPIO_DEBOUNCE_EN
    localparam int LAT = SS + DB;
`else
    localparam int LAT = SS;
`endif

    logic          HCLK;
    logic          HRESETn;
    logic [W-1:0]  WGPIODIN, WGPIODOUT, WGPIOPU, WGPIOPD, WGPIODIR;
    logic [W-1:0]  WGPIOIM, WGPIOIT, WGPIOIP, WGPIOIC, WGPIOIS;
    logic          IRQ;
    logic [W-1:0]  GPIOIN, GPIOOUT, GPIOPU, GPIOPD, GPIOOEN;

    int n_vec  = 0;
    int n_fail = 0;

    gpio_ctrl #(.WIDTH(W), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DB)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .WGPIODIN(WGPIODIN),
        .WGPIODOUT(WGPIODOUT), .WGPIOPU(WGPIOPU), .WGPIOPD(WGPIOPD),
        .WGPIODIR(WGPIODIR), .WGPIOIM(WGPIOIM), .WGPIOIT(WGPIOIT),
        .WGPIOIP(WGPIOIP), .WGPIOIC(WGPIOIC), .WGPIOIS(WGPIOIS), .IRQ(IRQ),
        .GPIOIN(GPIOIN), .GPIOOUT(GPIOOUT), .GPIOPU(GPIOPU),
        .GPIOPD(GPIOPD), .GPIOOEN(GPIOOEN)
    );

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge HCLK);
        #1;
    endtask

    // Reference model: val is the pad delayed by SS samples (then filtered),
    // status follows the per-pin set/clear rules directly.
    logic [W-1:0] pad_q[$];
    logic [W-1:0] m_sync, m_val, m_prev, m_status;
`ifdef GPIO_DEBOUNCE_EN
    logic [W-1:0] m_stable;
    int           run [W];
`endif

    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            pad_q.delete();
            m_sync = '0; m_val = '0; m_prev = '0; m_status = '0;
`ifdef GPIO_DEBOUNCE_EN
            m_stable = '0;
            for (int i = 0; i < W; i++) run[i] = 0;
`endif
        end else begin
            logic [W-1:0] ev;
            for (int i = 0; i < W; i++) begin
                if (!WGPIOIT[i]) ev[i] = WGPIOIP[i] ? m_val[i] : !m_val[i];
                else             ev[i] = WGPIOIP[i] ? (m_val[i] && !m_prev[i])
                                                    : (!m_val[i] && m_prev[i]);
            end
            m_status = ev | (m_status & ~WGPIOIC);
            m_prev   = m_val;
`ifdef GPIO_DEBOUNCE_EN
            for (int i = 0; i < W; i++) begin
                if (m_sync[i] != m_stable[i]) begin
                    run[i]++;
                    if (run[i] == DB) begin
                        m_stable[i] = m_sync[i];
                        run[i] = 0;
                    end
                end else begin
                    run[i] = 0;
                end
            end
`endif
            pad_q.push_front(GPIOIN);
            if (pad_q.size() > SS) void'(pad_q.pop_back());
            m_sync = (pad_q.size() == SS) ? pad_q[SS-1] : '0;
`ifdef GPIO_DEBOUNCE_EN
            m_val = m_stable;
`else
            m_val = m_sync;
`endif
        end
    end

    always @(negedge HCLK) begin
        check("din", 64'(WGPIODIN), 64'(m_val));
        check("status", 64'(WGPIOIS), 64'(m_status));
        check("irq", 64'(IRQ), 64'(|(m_status & WGPIOIM)));
        check("pads", {GPIOOUT, GPIOOEN, GPIOPU, GPIOPD},
                      {WGPIODOUT, WGPIODIR, WGPIOPU, WGPIOPD});
    end

    initial begin
        HRESETn   = 1'b0;
        GPIOIN    = '0;
        WGPIODOUT = 16'hA5A5;
        WGPIODIR  = 16'h00FF;
        WGPIOPU   = 16'h0F0F;
        WGPIOPD   = 16'hF0F0;
        WGPIOIT   = 16'hFFFF;
        WGPIOIP   = 16'hFFFF;
        WGPIOIM   = 16'h0008;
        WGPIOIC   = '0;

        // reset and pass-through
        step(2);
        check("rst_out", 64'(GPIOOUT), 64'h A5A5);
        check("rst_oen", 64'(GPIOOEN), 64'h 00FF);
        check("rst_is", 64'(WGPIOIS), 64'h0);
        check("rst_irq", 64'(IRQ), 64'h0);
        check("rst_din", 64'(WGPIODIN), 64'h0);
        HRESETn = 1'b1;
        step(1);
        GPIOIN = 16'h1234;
        step(LAT);
        check("din_1234", 64'(WGPIODIN), 64'h1234);
        step(2);
        WGPIOIC = 16'hFFFF;
        step(1);
        WGPIOIC = '0;
        check("clr_all", 64'(WGPIOIS), 64'h0);

        // rising edge on pin 3
        WGPIODOUT = 16'h5A5A;
        GPIOIN    = 16'h123C;
        step(LAT);
        check("rise3_early", 64'(WGPIOIS[3]), 64'h0);
        check("pads_5a5a", 64'(GPIOOUT), 64'h5A5A);
        step(1);
        check("rise3_is", 64'(WGPIOIS[3]), 64'h1);
        check("rise3_irq", 64'(IRQ), 64'h1);
        WGPIOIC = 16'h0008;
        step(1);
        WGPIOIC = '0;
        check("rise3_clr_is", 64'(WGPIOIS[3]), 64'h0);
        check("rise3_clr_irq", 64'(IRQ), 64'h0);
        GPIOIN = 16'h1234;
        step(LAT + 2);
        check("fall3_noevt", 64'(WGPIOIS[3]), 64'h0);

        // level-low, masked pin 7
        WGPIOIT = 16'hFF7F;
        WGPIOIP = 16'hFF7F;
        step(1);
        check("lvl7_is", 64'(WGPIOIS[7]), 64'h1);
        check("lvl7_irq", 64'(IRQ), 64'h0);
        WGPIOIC = 16'h0080;
        step(1);
        WGPIOIC = '0;
        check("lvl7_sticky", 64'(WGPIOIS[7]), 64'h1);
        GPIOIN = 16'h12B4;
        step(LAT + 1);
        WGPIOIC = 16'h0080;
        step(1);
        WGPIOIC = '0;
        check("lvl7_cleared", 64'(WGPIOIS[7]), 64'h0);
        WGPIOIT = 16'hFFFF;
        WGPIOIP = 16'hFFFF;

        // simultaneous set and clear on pin 0
        GPIOIN = 16'h12B5;
        step(LAT);
        WGPIOIC = 16'h0001;
        step(1);
        check("setclr0", 64'(WGPIOIS[0]), 64'h1);
        WGPIOIC = '0;
        step(1);
        check("setclr0_hold", 64'(WGPIOIS[0]), 64'h1);

`ifdef GPIO_DEBOUNCE_EN
        // debounce: short glitch rejected, sustained level accepted
        GPIOIN = 16'h12B7;
        step(5);
        GPIOIN = 16'h12B5;
        step(LAT + 4);
        check("glitch_din", 64'(WGPIODIN[1]), 64'h0);
        check("glitch_is", 64'(WGPIOIS[1]), 64'h0);
        GPIOIN = 16'h12B7;
        step(LAT - 1);
        check("db_early", 64'(WGPIODIN[1]), 64'h0);
        step(1);
        check("db_accept", 64'(WGPIODIN[1]), 64'h1);
        step(1);
        check("db_is", 64'(WGPIOIS[1]), 64'h1);
`endif

        // asynchronous reset while status is pending
        WGPIOIC = 16'hFFFF;
        step(1);
        WGPIOIC = '0;
        GPIOIN  = GPIOIN | 16'h0008;
        step(LAT + 1);
        check("pre_rst_is", 64'(WGPIOIS), 64'h0008);
        check("pre_rst_irq", 64'(IRQ), 64'h1);
        #1;
        HRESETn = 1'b0;
        #1;
        check("async_rst_is", 64'(WGPIOIS), 64'h0);
        check("async_rst_irq", 64'(IRQ), 64'h0);
        check("async_rst_din", 64'(WGPIODIN), 64'h0);
        step(2);
        HRESETn = 1'b1;
        step(LAT + 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
